// File: rtl/dcache_banked_if.sv
// dcache_banked_if
// Bus bundle for dcache_banked: a DMA port and a core port, each with bank select,
// word address, write/read requests, write data, read data and a read-complete
// pulse. The DMA side also carries dma_ready, which reports arbitration.
// The master modport is the requester side (DMA engine plus core), and the slave
// modport is the cache.
// Optional macro DCACHE_PARITY_EN adds dma_parity_err and cpu_parity_err.
interface dcache_banked_if #(
    parameter int NUM_SLOTS = 4,
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 18,
    parameter int SLOT_W    = $clog2(NUM_SLOTS)
);
    logic [SLOT_W-1:0] dma_slot;
    logic [ADDR_W-1:0] dma_addr;
    logic              dma_we;
    logic [DATA_W-1:0] dma_dat_w;
    logic              dma_re;
    logic              dma_ready;
    logic [DATA_W-1:0] dma_dat_r;
    logic              dma_dcache_read_complete;

    logic [SLOT_W-1:0] cpu_slot;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_we;
    logic [DATA_W-1:0] cpu_dat_w;
    logic              cpu_re;
    logic [DATA_W-1:0] cpu_dat_r;
    logic              cpu_read_complete;

`ifdef DCACHE_PARITY_EN
    logic              dma_parity_err;
    logic              cpu_parity_err;

    modport master (
        output dma_slot, dma_addr, dma_we, dma_dat_w, dma_re,
        input  dma_ready, dma_dat_r, dma_dcache_read_complete, dma_parity_err,
        output cpu_slot, cpu_addr, cpu_we, cpu_dat_w, cpu_re,
        input  cpu_dat_r, cpu_read_complete, cpu_parity_err
    );

    modport slave (
        input  dma_slot, dma_addr, dma_we, dma_dat_w, dma_re,
        output dma_ready, dma_dat_r, dma_dcache_read_complete, dma_parity_err,
        input  cpu_slot, cpu_addr, cpu_we, cpu_dat_w, cpu_re,
        output cpu_dat_r, cpu_read_complete, cpu_parity_err
    );
`else
    modport master (
        output dma_slot, dma_addr, dma_we, dma_dat_w, dma_re,
        input  dma_ready, dma_dat_r, dma_dcache_read_complete,
        output cpu_slot, cpu_addr, cpu_we, cpu_dat_w, cpu_re,
        input  cpu_dat_r, cpu_read_complete
    );

    modport slave (
        input  dma_slot, dma_addr, dma_we, dma_dat_w, dma_re,
        output dma_ready, dma_dat_r, dma_dcache_read_complete,
        input  cpu_slot, cpu_addr, cpu_we, cpu_dat_w, cpu_re,
        output cpu_dat_r, cpu_read_complete
    );
`endif
endinterface

// File: rtl/dcache_banked.sv
// dcache_banked
// This is a banked data cache with NUM_SLOTS banks. Each bank holds 2^ADDR_W words,
// and each word is DATA_W bits wide.
// There are two ports. The DMA port fills and drains the cache. The core port
// serves loads and stores from the execution unit.
// When both ports are active on the same bank, the core wins and dma_ready drops.
// The DMA request is then dropped and must be held by the requester.
// Read data and the complete pulse appear READ_LATENCY cycles (1 or 2) after the
// read is accepted.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : dcache_banked_if.slave (DMA and core request/response signals)
// Optional macro DCACHE_PARITY_EN stores an even-parity bit per word. It flags a
// mismatch on dma_parity_err or cpu_parity_err, together with the matching
// complete pulse.
module dcache_banked #(
    parameter int NUM_SLOTS    = 4,
    parameter int ADDR_W       = 11,
    parameter int DATA_W       = 18,
    parameter int READ_LATENCY = 1,
    parameter int SLOT_W       = $clog2(NUM_SLOTS)
) (
    input logic           clk,
    input logic           reset,
    dcache_banked_if.slave bus
);
    localparam int IDX_W = SLOT_W + ADDR_W;
    localparam int DEPTH = 2 ** IDX_W;
`ifdef DCACHE_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    // All banks share one array indexed by {slot, addr}. The core and DMA ports
    // only ever write the same entry in a conflict cycle, and in that cycle the
    // DMA access is blocked.
    logic [MEM_W-1:0] mem [DEPTH];

    function automatic logic [MEM_W-1:0] encode(input logic [DATA_W-1:0] d);
`ifdef DCACHE_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    logic             cpu_act, dma_act, conflict, dma_acc;
    logic             cpu_wr, cpu_rd, dma_wr, dma_rd;
    logic [IDX_W-1:0] cpu_idx, dma_idx;

    assign cpu_idx  = {bus.cpu_slot, bus.cpu_addr};
    assign dma_idx  = {bus.dma_slot, bus.dma_addr};
    assign cpu_act  = bus.cpu_we | bus.cpu_re;
    assign dma_act  = bus.dma_we | bus.dma_re;
    assign conflict = cpu_act & dma_act & (bus.cpu_slot == bus.dma_slot);

    assign bus.dma_ready = ~reset & ~conflict;
    assign dma_acc       = dma_act & bus.dma_ready;

    // A request with both we and re set is treated as a write only.
    assign cpu_wr = ~reset & bus.cpu_we;
    assign cpu_rd = ~reset & bus.cpu_re & ~bus.cpu_we;
    assign dma_wr = dma_acc & bus.dma_we;
    assign dma_rd = dma_acc & bus.dma_re & ~bus.dma_we;

    always_ff @(posedge clk) begin
        if (cpu_wr) mem[cpu_idx] <= encode(bus.cpu_dat_w);
        if (dma_wr) mem[dma_idx] <= encode(bus.dma_dat_w);
    end

    // The first read stage captures the word on the accepting edge.
    // The data registers only load on a read, so they hold their value otherwise.
    logic             cpu_v1, dma_v1;
    logic [MEM_W-1:0] cpu_q1, dma_q1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_v1 <= 1'b0;
            dma_v1 <= 1'b0;
            cpu_q1 <= '0;
            dma_q1 <= '0;
        end else begin
            cpu_v1 <= cpu_rd;
            dma_v1 <= dma_rd;
            if (cpu_rd) cpu_q1 <= mem[cpu_idx];
            if (dma_rd) dma_q1 <= mem[dma_idx];
        end
    end

    logic             cpu_vo, dma_vo;
    logic [MEM_W-1:0] cpu_qo, dma_qo;

    if (READ_LATENCY == 2) begin : g_lat2
        logic             cpu_v2, dma_v2;
        logic [MEM_W-1:0] cpu_q2, dma_q2;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cpu_v2 <= 1'b0;
                dma_v2 <= 1'b0;
                cpu_q2 <= '0;
                dma_q2 <= '0;
            end else begin
                cpu_v2 <= cpu_v1;
                dma_v2 <= dma_v1;
                if (cpu_v1) cpu_q2 <= cpu_q1;
                if (dma_v1) dma_q2 <= dma_q1;
            end
        end

        assign cpu_vo = cpu_v2;
        assign dma_vo = dma_v2;
        assign cpu_qo = cpu_q2;
        assign dma_qo = dma_q2;
    end else begin : g_lat1
        assign cpu_vo = cpu_v1;
        assign dma_vo = dma_v1;
        assign cpu_qo = cpu_q1;
        assign dma_qo = dma_q1;
    end

    assign bus.cpu_dat_r                = cpu_qo[DATA_W-1:0];
    assign bus.cpu_read_complete        = cpu_vo;
    assign bus.dma_dat_r                = dma_qo[DATA_W-1:0];
    assign bus.dma_dcache_read_complete = dma_vo;

`ifdef DCACHE_PARITY_EN
    // With even parity, a clean stored word XOR-reduces to zero.
    assign bus.cpu_parity_err = cpu_vo & (^cpu_qo);
    assign bus.dma_parity_err = dma_vo & (^dma_qo);
`endif
endmodule
